// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: req/ready handshake with configurable wait states,
// byte-enable writes to on-chip RAM, plus a GPIO register and a free-running cycle counter.
module dmem_ctrl #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned WAIT      = 1,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd,
  output logic        o_ready,
  output logic        o_err,
  output logic [31:0] o_gpio_out
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] GpioAddr = MMIO_BASE;
  localparam logic [31:0] CntAddr  = MMIO_BASE + 32'd4;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic          w_access;
  logic [3:0]    r_wait;
  logic [29:0]   r_word;
  logic          r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_wd;
  logic [31:0]   r_rd;
  logic          r_err;
  logic [31:0]   r_gpio;
  logic [31:0]   r_cycle;
  logic [31:0]   r_mem [DEPTH];

  logic          w_is_ram;
  logic          w_is_gpio;
  logic          w_is_cnt;
  logic [AW-1:0] w_idx;
  logic          w_unused_adr;

  // Accesses are word-aligned; the byte offset carries no information.
  assign w_unused_adr = ^i_adr[1:0];

  assign w_is_ram  = ({2'b00, r_word} < 32'(DEPTH));
  assign w_is_gpio = ({r_word, 2'b00} == GpioAddr);
  assign w_is_cnt  = ({r_word, 2'b00} == CntAddr);
  assign w_idx     = r_word[AW-1:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_access     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req) w_state_next = StBusy;
      end
      StBusy: begin
        if (r_wait == 4'd0) begin
          w_access     = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wait  <= 4'd0;
      r_word  <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'd0;
      r_wd    <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
      r_gpio  <= '0;
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;

      if (r_state == StIdle && i_req) begin
        r_word <= i_adr[31:2];
        r_we   <= i_we;
        r_be   <= i_be;
        r_wd   <= i_wd;
        r_wait <= 4'(WAIT);
      end else if (r_state == StBusy && r_wait != 4'd0) begin
        r_wait <= r_wait - 4'd1;
      end

      if (w_access) begin
        r_rd  <= '0;
        r_err <= 1'b0;
        if (w_is_ram) begin
          if (!r_we) r_rd <= r_mem[w_idx];
        end else if (w_is_gpio) begin
          if (r_we) begin
            for (int i = 0; i < 4; i++) begin
              if (r_be[i]) r_gpio[8*i +: 8] <= r_wd[8*i +: 8];
            end
          end else begin
            r_rd <= r_gpio;
          end
        end else if (w_is_cnt) begin
          // Counter writes are silently dropped.
          if (!r_we) r_rd <= r_cycle;
        end else begin
          r_err <= 1'b1;
        end
      end else if (r_state == StResp) begin
        r_rd  <= '0;
        r_err <= 1'b0;
      end
    end
  end

  // RAM is not reset; reset still blocks a write on the edge it is asserted.
  always_ff @(posedge i_clk) begin
    if (w_access && w_is_ram && r_we && !i_reset) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wd[8*i +: 8];
      end
    end
  end

  assign o_rd       = r_rd;
  assign o_err      = r_err;
  assign o_ready    = (r_state == StResp);
  assign o_gpio_out = r_gpio;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (WAIT = 1, 0, 15) driven with directed and random
// accesses and compared against a word-level memory/GPIO/counter model.
module tb_dmem_ctrl;

  localparam int          NDUT = 3;
  localparam logic [31:0] MMIO = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst   [NDUT];
  logic        req   [NDUT];
  logic        we    [NDUT];
  logic [31:0] adr   [NDUT];
  logic [3:0]  be    [NDUT];
  logic [31:0] wd    [NDUT];
  logic [31:0] rd    [NDUT];
  logic        ready [NDUT];
  logic        err   [NDUT];
  logic [31:0] gpio  [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_mem  [NDUT][64];
  logic [31:0] m_gpio [NDUT];
  logic [31:0] m_cyc  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_ctrl #(
      .DEPTH    (64),
      .WAIT     ((g == 0) ? 1 : (g == 1) ? 0 : 15),
      .MMIO_BASE(MMIO)
    ) u_dut (
      .i_clk     (clk),
      .i_reset   (rst[g]),
      .i_req     (req[g]),
      .i_we      (we[g]),
      .i_adr     (adr[g]),
      .i_be      (be[g]),
      .i_wd      (wd[g]),
      .o_rd      (rd[g]),
      .o_ready   (ready[g]),
      .o_err     (err[g]),
      .o_gpio_out(gpio[g])
    );
  end

  // Edges elapsed since reset was released.
  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (rst[k]) m_cyc[k] = 32'd0;
      else        m_cyc[k] = m_cyc[k] + 32'd1;
    end
  end

  function automatic int unsigned wait_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 15;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic access(input int k, input bit w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] got_rd);
    logic [31:0] snap;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [29:0] wrd;
    int          n;
    bit          seen;
    req[k] = 1'b1; we[k] = w; adr[k] = a; be[k] = b; wd[k] = d;
    n = 0; seen = 0; snap = '0; got_rd = '0;
    while (!seen && n < 40) begin
      snap = m_cyc[k];
      @(negedge clk);
      n++;
      if (ready[k]) begin
        seen = 1;
      end else begin
        adr[k] = $urandom; wd[k] = $urandom; be[k] = 4'($urandom); we[k] = 1'($urandom);
      end
    end
    check("latency", 32'(n), 32'(wait_of(k) + 2));
    if (!seen) begin
      req[k] = 1'b0;
      return;
    end
    wrd     = a[31:2];
    exp_rd  = '0;
    exp_err = 1'b0;
    if (wrd < 30'd64) begin
      if (w) m_mem[k][wrd[5:0]] = merge(m_mem[k][wrd[5:0]], d, b);
      else   exp_rd = m_mem[k][wrd[5:0]];
    end else if ({wrd, 2'b00} == MMIO) begin
      if (w) m_gpio[k] = merge(m_gpio[k], d, b);
      else   exp_rd = m_gpio[k];
    end else if ({wrd, 2'b00} == MMIO + 32'd4) begin
      if (!w) exp_rd = snap;
    end else begin
      exp_err = 1'b1;
    end
    check("rd", rd[k], exp_rd);
    check("err", 32'(err[k]), 32'(exp_err));
    check("gpio_resp", gpio[k], m_gpio[k]);
    got_rd = rd[k];
    req[k] = 1'b0;
    @(negedge clk);
    check("ready_single", 32'(ready[k]), 32'd0);
  endtask

  task automatic abort_write(input int k, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    req[k] = 1'b1; we[k] = 1'b1; adr[k] = a; be[k] = 4'hF; wd[k] = d;
    @(negedge clk);
    rst[k] = 1'b1;
    req[k] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_ready", 32'(ready[k]), 32'd0);
    end
    rst[k]    = 1'b0;
    m_gpio[k] = '0;
    check("abort_gpio", gpio[k], 32'd0);
    access(k, 1'b0, a, 4'hF, '0, r);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [31:0] a;
    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; adr[k] = '0; be[k] = '0; wd[k] = '0;
      m_gpio[k] = '0; m_cyc[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check("rst_ready", 32'(ready[k]), 32'd0);
      check("rst_err", 32'(err[k]), 32'd0);
      check("rst_rd", rd[k], 32'd0);
      check("rst_gpio", gpio[k], 32'd0);
      rst[k] = 1'b0;
    end

    // Give every RAM word a known value.
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 64; i++) access(k, 1'b1, 32'(i * 4), 4'hF, $urandom, r);
    end

    // Basic write/read-back at every wait-state setting.
    for (int k = 0; k < NDUT; k++) begin
      access(k, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, r);
      access(k, 1'b0, 32'h10, 4'hF, '0, r);
      check("s1_rd", r, 32'hDEADBEEF);
    end

    access(0, 1'b1, 32'h20, 4'hF, 32'h11223344, r);
    access(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, r);
    access(0, 1'b0, 32'h20, 4'hF, '0, r);
    check("s2_rd", r, 32'h11BB33DD);

    access(0, 1'b1, MMIO, 4'hF, 32'h0000_00A5, r);
    check("s3_gpio", gpio[0], 32'h0000_00A5);
    access(0, 1'b0, MMIO + 32'd4, 4'hF, '0, c1);
    access(0, 1'b0, MMIO + 32'd4, 4'hF, '0, c2);
    check("s3_cnt_delta", c2 - c1, 32'(wait_of(0) + 3));

    access(0, 1'b0, 32'h0000_1000, 4'hF, '0, r);
    access(0, 1'b1, 32'h0000_1000, 4'hF, 32'hCAFEF00D, r);
    access(0, 1'b0, 32'h0, 4'hF, '0, r);

    for (int k = 0; k < NDUT; k++) abort_write(k, 32'h08, 32'h5A5A_A5A5);

    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 60; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
          6:                a = MMIO | 32'($urandom_range(0, 3));
          7:                a = MMIO + 32'd4;
          8:                a = 32'h0000_1000 + ($urandom & 32'hFFFF);
          default:          a = $urandom;
        endcase
        access(k, 1'($urandom), a, 4'($urandom), $urandom, r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, multi-cycle data-memory controller for the MIPS system: replaces the single-cycle word-only data memory with a request/ready handshake, a configurable number of wait states, byte-enable writes and a small memory-mapped I/O region. It sits between the processor's load/store port and on-chip RAM. It gives the processor a stall source and a first peripheral, a GPIO output register and a cycle counter.

## Interface
Parameters:
- DEPTH, 64: RAM size in 32-bit words, a power of two from 16 to 4096. RAM occupies byte addresses 0 to DEPTH*4-1.
- WAIT, 1: wait states per access, range 0 to 15.
- MMIO_BASE, 32'hFFFF_0000: byte address of the GPIO register. The cycle counter is at MMIO_BASE+4.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request; the master holds it high until it sees ready.
- we  in  1  1 = write, 0 = read.
- adr  in  32  byte address; bits [1:0] are ignored, so accesses are word-aligned.
- be  in  4  byte enables for writes; be[i] selects wd[8i+7:8i]. Ignored on reads.
- wd  in  32  write data.
- rd  out  32  read data, valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  decode error, valid only while ready=1.
- gpio_out  out  32  GPIO register value.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- IDLE:
  - On an edge with req=1, latch adr, we, be and wd.
  - Load the wait counter with WAIT and go to BUSY.
  - Changes to the inputs after this edge have no effect on the access.
- BUSY:
  - While the wait counter is greater than 0, each edge decrements it.
  - On the edge where the counter equals 0, perform the access and go to RESP.
- RESP:
  - ready=1 for exactly this one cycle; rd and err are driven from registers.
  - The next edge always returns to IDLE. req is ignored in RESP.
  - The master drops req in the ready cycle; if req is still high in IDLE, a new access starts.
- Address decode, using the latched address:
  - Address below DEPTH*4: RAM word adr[log2(DEPTH)+1:2].
  - Address equal to MMIO_BASE: the GPIO register, read/write with byte enables.
  - Address equal to MMIO_BASE+4: the cycle counter, read-only; writes are dropped with err=0.
  - Any other address: err=1, rd=0, nothing is written.
- Writes:
  - Only the bytes selected by be are updated.
  - be=4'b0000 completes normally and changes nothing.
  - rd=0 for writes.
- Reads return the full 32-bit word; the processor performs byte/halfword extraction.
- Cycle counter: 32-bit, increments on every edge, wraps from 32'hFFFF_FFFF to 0. A read returns the value held just before the access edge.
- gpio_out is driven directly from the GPIO register, and an update is visible in the RESP cycle.

## Timing
- Reset values: state=IDLE, ready=0, err=0, rd=0, gpio_out=0, cycle counter=0, wait counter=0. RAM contents are not reset and keep their prior values.
- Reset asserted mid-access (BUSY or RESP):
  - Abort immediately and produce no ready.
  - A pending write that has not reached its access edge is discarded.
- Latency:
  - req is sampled at edge E0.
  - The access takes place at edge E0+WAIT+1; ready is high in the cycle that follows it.
  - This gives WAIT+2 cycles from req to ready.
- Throughput: one access every WAIT+3 cycles when req is re-asserted immediately.
- ready is never high for two consecutive cycles.
- rd, err and ready change only on clock edges or on reset; there is no combinational path from the inputs.

## Test plan
1. Reset, then write 32'hDEADBEEF to 0x10 with be=4'hF and read it back, using WAIT=1.
   - Required: ready is high exactly 3 cycles after each req; rd=32'hDEADBEEF; err=0.
2. Starting from word 0x20 = 32'h11223344, write be=4'b0101 with wd=32'hAABBCCDD, then read.
   - Required: rd=32'h11BB33DD.
3. Write 32'h0000_00A5 to MMIO_BASE, then read MMIO_BASE+4 twice with back-to-back accesses.
   - Required: gpio_out=32'hA5 in the RESP cycle.
   - Required: the two counter reads differ by exactly WAIT+3.
4. Read 0x0000_1000 with DEPTH=64, then write there.
   - Required: ready=1, err=1, rd=0; RAM is unchanged.
5. Assert reset during BUSY of a write to 0x08, then release it and read 0x08.
   - Required: no ready pulse during the aborted write; the old data is returned; gpio_out=0.
6. Repeat scenario 1 with WAIT=0 and WAIT=15, changing adr and wd while in BUSY.
   - Required: latency of 2 and 17 cycles respectively; the originally latched values are used.
